// File: rtl/pipeline_pkg.sv
// Shared definitions for the series-evaluation pipeline: controller states and
// Q16.16 format constants.
package pipeline_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned FRAC    = 16;
    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/saturating_adder.sv
// Combinational signed adder that clamps to the representable range and flags the clamp.
// Shared by any pipeline stage that needs saturating accumulation.
module saturating_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_sat_flag
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] w_wide;

    // One guard bit: the top two bits differ exactly when the true sum is out of range.
    assign w_wide = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

    always_comb begin
        o_sum      = w_wide[WIDTH-1:0];
        o_sat_flag = 1'b0;
        if (w_wide[WIDTH] != w_wide[WIDTH-1]) begin
            o_sat_flag = 1'b1;
            o_sum      = w_wide[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/pipeline_stage_accumulate.sv
// Pipeline sink: sums NUM_TERMS signed terms onto 1.0 with saturation and hands one
// result per evaluation downstream over a valid/ready handshake.
module pipeline_stage_accumulate #(
    parameter int unsigned NUM_TERMS = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC      = pipeline_pkg::FRAC
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_term_valid,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_term_ready,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_busy
);

    import pipeline_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_TERMS - 1);
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_overflow;
    logic               w_overflow_next;
    logic [WIDTH-1:0]   w_sum;
    logic               w_sat;
    logic               w_term_ready;
    logic               w_result_valid;

    saturating_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a        (r_acc),
        .i_b        (i_term),
        .o_sum      (w_sum),
        .o_sat_flag (w_sat)
    );

    always_comb begin
        w_state_next    = r_state;
        w_acc_next      = r_acc;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        w_term_ready    = 1'b0;
        w_result_valid  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next    = StAccum;
                    w_acc_next      = ONE_VAL;
                    w_count_next    = '0;
                    w_overflow_next = 1'b0;
                end
            end
            StAccum: begin
                w_term_ready = 1'b1;
                if (i_term_valid) begin
                    w_count_next = r_count + CNT_W'(1);
                    // Once clamped the accumulator is frozen; terms are still drained.
                    if (!r_overflow) begin
                        w_acc_next      = w_sum;
                        w_overflow_next = w_sat;
                    end
                    if (r_count == LAST) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                w_result_valid = 1'b1;
                if (i_result_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_term_ready   = w_term_ready;
    assign o_result_valid = w_result_valid;
    assign o_result       = r_acc;
    assign o_overflow     = r_overflow;
    assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_pipeline_stage_accumulate.sv
// Directed bench for pipeline_stage_accumulate with hand-computed Q16.16 expectations.
module tb_pipeline_stage_accumulate;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        term_valid;
    logic [31:0] term;
    logic        term_ready;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    pipeline_stage_accumulate #(
        .NUM_TERMS (4),
        .WIDTH     (32),
        .FRAC      (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_term_valid   (term_valid),
        .i_term         (term),
        .o_term_ready   (term_ready),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready),
        .o_result       (result),
        .o_overflow     (overflow),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (term_valid && term_ready) n_acc <= n_acc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents a term after `gap` idle cycles and waits (bounded) for its handshake.
    task automatic send_term(input logic [31:0] t, input int gap);
        int waited;
        term_valid = 1'b0;
        repeat (gap) @(negedge clk);
        term_valid = 1'b1;
        term       = t;
        waited     = 0;
        while (!term_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!term_ready) check("term_ready_timeout", 32'(term_ready), 32'd1);
        @(negedge clk);
        term_valid = 1'b0;
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        term_valid   = 1'b0;
        term         = '0;
        result_ready = 1'b0;
        @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_term_ready", 32'(term_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_term_ready", 32'(term_ready), 32'd0);

        // Nominal e^1 partial sum
        do_start();
        check("nom_busy", 32'(busy), 32'd1);
        check("nom_term_ready", 32'(term_ready), 32'd1);
        check("nom_start_acc", result, 32'h0001_0000);
        send_term(32'h0001_0000, 0);
        send_term(32'h0000_8000, 0);
        send_term(32'h0000_2AAB, 0);
        check("nom_valid_early", 32'(result_valid), 32'd0);
        send_term(32'h0000_0AAB, 0);
        check("nom_valid", 32'(result_valid), 32'd1);
        check("nom_result", result, 32'h0002_B556);
        check("nom_overflow", 32'(overflow), 32'd0);
        check("nom_term_ready_done", 32'(term_ready), 32'd0);
        take_result();
        check("nom_idle_busy", 32'(busy), 32'd0);
        check("nom_idle_valid", 32'(result_valid), 32'd0);

        // Positive saturation on the very first term
        @(negedge clk);
        n_acc = 0;
        do_start();
        send_term(32'h7FFF_0000, 0);
        check("pos_clamp", result, 32'h7FFF_FFFF);
        check("pos_ovf_early", 32'(overflow), 32'd1);
        send_term(32'h0002_0000, 0);
        send_term(32'h0000_0001, 0);
        send_term(32'h0000_0001, 0);
        check("pos_valid", 32'(result_valid), 32'd1);
        check("pos_result", result, 32'h7FFF_FFFF);
        check("pos_overflow", 32'(overflow), 32'd1);
        check("pos_accepts", 32'(n_acc), 32'd4);
        take_result();

        // Negative boundary: exact minimum, then clamp
        do_start();
        send_term(32'h8000_0000, 0);
        send_term(32'hFFFF_0000, 0);
        check("neg_exact", result, 32'h8000_0000);
        check("neg_exact_ovf", 32'(overflow), 32'd0);
        send_term(32'hFFFF_FFFF, 0);
        check("neg_clamp", result, 32'h8000_0000);
        check("neg_clamp_ovf", 32'(overflow), 32'd1);
        send_term(32'h0000_0000, 0);
        check("neg_result", result, 32'h8000_0000);
        check("neg_overflow", 32'(overflow), 32'd1);
        take_result();

        // Backpressure with stray terms and a start pulse while DONE
        do_start();
        for (int i = 0; i < 4; i++) send_term(32'h0000_1000, 0);
        n_acc      = 0;
        term_valid = 1'b1;
        term       = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            check("bp_term_ready", 32'(term_ready), 32'd0);
            check("bp_result", result, 32'h0001_4000);
            check("bp_valid", 32'(result_valid), 32'd1);
        end
        start      = 1'b0;
        term_valid = 1'b0;
        check("bp_no_accepts", 32'(n_acc), 32'd0);
        take_result();
        check("bp_busy", 32'(busy), 32'd0);
        check("bp_valid_drop", 32'(result_valid), 32'd0);
        @(negedge clk);
        check("bp_start_not_queued", 32'(busy), 32'd0);

        // Asynchronous reset mid-ACCUM
        do_start();
        send_term(32'h0003_0000, 0);
        send_term(32'h0003_0000, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_term_ready", 32'(term_ready), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        for (int i = 0; i < 4; i++) send_term(32'h0000_0000, 0);
        check("post_rst_result", result, 32'h0001_0000);
        check("post_rst_valid", 32'(result_valid), 32'd1);
        take_result();

        // Sparse input with random gaps
        n_acc = 0;
        do_start();
        for (int i = 0; i < 4; i++) send_term(32'h0000_4000, int'($urandom_range(0, 3)));
        check("sparse_result", result, 32'h0002_0000);
        check("sparse_valid", 32'(result_valid), 32'd1);
        check("sparse_accepts", 32'(n_acc), 32'd4);
        take_result();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
